// File: rtl/int_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// int_ctrl_pkg
// Shared definitions for the interrupt controller:
//   - register address map (MASK, PENDING, CAUSE, GIE)
//   - controller state enumeration
//   - CAUSE register field positions and a helper that packs the CAUSE word
// -----------------------------------------------------------------------------
package int_ctrl_pkg;

    localparam logic [1:0] ADDR_MASK    = 2'd0;
    localparam logic [1:0] ADDR_PENDING = 2'd1;
    localparam logic [1:0] ADDR_CAUSE   = 2'd2;
    localparam logic [1:0] ADDR_GIE     = 2'd3;

    localparam int CAUSE_VALID_BIT = 31;
    localparam int CAUSE_ID_LSB    = 0;
    localparam int CAUSE_ID_W      = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

    // Builds the 32-bit CAUSE read value; all bits outside the fields read 0.
    function automatic logic [31:0] pack_cause(input logic valid,
                                               input logic [CAUSE_ID_W-1:0] id);
        logic [31:0] word;
        word = '0;
        word[CAUSE_VALID_BIT] = valid;
        word[CAUSE_ID_LSB +: CAUSE_ID_W] = id;
        return word;
    endfunction

endpackage

// File: rtl/int_prio_enc.sv
// -----------------------------------------------------------------------------
// int_prio_enc
// Combinational priority encoder, lowest index wins.
// Ports:
//   req  in   NUM_SRC  request vector (already qualified by the caller)
//   id   out  4        index of the lowest set bit (0 when none set)
//   any  out  1        high when at least one request bit is set
// -----------------------------------------------------------------------------
module int_prio_enc
    import int_ctrl_pkg::*;
#(
    parameter int NUM_SRC = 8
) (
    input  logic [NUM_SRC-1:0]    req,
    output logic [CAUSE_ID_W-1:0] id,
    output logic                  any
);

    // Scanning from the top down lets the lowest set index overwrite the rest.
    always_comb begin
        id  = '0;
        any = |req;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (req[i]) begin
                id = CAUSE_ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/int_controller.sv
// -----------------------------------------------------------------------------
// int_controller
// Edge-triggered, non-nesting interrupt controller with per-source pending
// bits, a mask, a global enable and a CAUSE register.
//
// Parameters:
//   NUM_SRC  number of interrupt sources, 1..16 (bit 0 = highest priority)
// Ports:
//   clk    in   1        system clock, rising edge
//   reset  in   1        asynchronous, active-high reset
//   irq    in   NUM_SRC  peripheral interrupt request levels
//   eret   in   1        return-from-interrupt strobe
//   we     in   1        register write strobe
//   addr   in   2        register select: 0 MASK, 1 PENDING, 2 CAUSE, 3 GIE
//   wdata  in   32       write data
//   rdata  out  32       combinational read data for addr
//   INT    out  1        one-cycle interrupt strobe to the CPU
//   busy   out  1        high while an interrupt is in service
//
// Build option:
//   INT_SYNC_EN  when defined, each irq bit passes through a two-flop
//                synchronizer before edge detection (two extra cycles).
// -----------------------------------------------------------------------------
module int_controller
    import int_ctrl_pkg::*;
#(
    parameter int NUM_SRC = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] irq,
    input  logic               eret,
    input  logic               we,
    input  logic [1:0]         addr,
    input  logic [31:0]        wdata,
    output logic [31:0]        rdata,
    output logic               INT,
    output logic               busy
);

    logic [NUM_SRC-1:0]    irq_s;
    logic [NUM_SRC-1:0]    irq_q;
    logic [NUM_SRC-1:0]    irq_edge;
    logic [NUM_SRC-1:0]    pending;
    logic [NUM_SRC-1:0]    pending_next;
    logic [NUM_SRC-1:0]    mask;
    logic [NUM_SRC-1:0]    qualified;
    logic [NUM_SRC-1:0]    take_onehot;
    logic                  gie;
    logic                  cause_valid;
    logic [CAUSE_ID_W-1:0] cause_id;
    logic [CAUSE_ID_W-1:0] enc_id;
    logic                  enc_any;
    logic                  take;
    state_t                state;
    state_t                state_next;

    // Only the low NUM_SRC bits of wdata are architecturally meaningful.
    logic unused_wdata;
    assign unused_wdata = ^wdata;

`ifdef INT_SYNC_EN
    logic [NUM_SRC-1:0] sync1;
    logic [NUM_SRC-1:0] sync2;

    // Two-flop synchronizer for asynchronous peripheral request lines.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= irq;
            sync2 <= sync1;
        end
    end

    assign irq_s = sync2;
`else
    assign irq_s = irq;
`endif

    // irq_q resets to 0 so a line already high at reset release counts as
    // a rising edge on the first clock.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_q <= '0;
        end else begin
            irq_q <= irq_s;
        end
    end

    assign irq_edge  = irq_s & ~irq_q;
    assign qualified = pending & mask;

    int_prio_enc #(
        .NUM_SRC (NUM_SRC)
    ) u_prio_enc (
        .req (qualified),
        .id  (enc_id),
        .any (enc_any)
    );

    assign take_onehot = NUM_SRC'(1'b1) << enc_id;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. take marks the edge at which a source is accepted;
    // GIE and MASK only gate acceptance, never an interrupt already in flight.
    always_comb begin
        state_next = state;
        take       = 1'b0;
        case (state)
            IDLE: begin
                if (gie && enc_any) begin
                    state_next = REQ;
                    take       = 1'b1;
                end
            end
            REQ: begin
                state_next = SERVICE;
            end
            SERVICE: begin
                if (eret) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Output decode. state is a register, so INT is a one-cycle strobe that
    // lasts exactly the REQ cycle.
    always_comb begin
        INT  = (state == REQ);
        busy = (state == REQ) || (state == SERVICE);
    end

    // Pending update order matters: software clear and controller clear are
    // applied first, then new edges are OR-ed in so a coinciding edge wins.
    always_comb begin
        pending_next = pending;
        if (we && (addr == ADDR_PENDING)) begin
            pending_next = pending_next & ~wdata[NUM_SRC-1:0];
        end
        if (take) begin
            pending_next = pending_next & ~take_onehot;
        end
        pending_next = pending_next | irq_edge;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending <= '0;
            mask    <= '0;
            gie     <= 1'b0;
        end else begin
            pending <= pending_next;
            if (we && (addr == ADDR_MASK)) begin
                mask <= wdata[NUM_SRC-1:0];
            end
            if (we && (addr == ADDR_GIE)) begin
                gie <= wdata[0];
            end
        end
    end

    // CAUSE is not software-writable. The id is kept after eret so software
    // can still see which source was serviced last.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cause_valid <= 1'b0;
            cause_id    <= '0;
        end else if (take) begin
            cause_valid <= 1'b1;
            cause_id    <= enc_id;
        end else if ((state == SERVICE) && eret) begin
            cause_valid <= 1'b0;
        end
    end

    always_comb begin
        rdata = '0;
        case (addr)
            ADDR_MASK:    rdata = 32'(mask);
            ADDR_PENDING: rdata = 32'(pending);
            ADDR_CAUSE:   rdata = pack_cause(cause_valid, cause_id);
            ADDR_GIE:     rdata = 32'(gie);
            default:      rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_int_controller.sv
// -----------------------------------------------------------------------------
// tb_int_controller
// Directed bench for int_controller. Expected INT events (cycle and CAUSE
// value) are queued by the stimulus; an independent monitor pops and
// compares them whenever INT is seen. Register reads are checked directly.
// Define INT_SYNC_EN for both bench and RTL to exercise the synchronizer build.
// -----------------------------------------------------------------------------
module tb_int_controller;
    import int_ctrl_pkg::*;

`ifdef INT_SYNC_EN
    localparam int LAT       = 4;
    localparam int REL_TICKS = 3;
`else
    localparam int LAT       = 2;
    localparam int REL_TICKS = 1;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  irq;
    logic        eret;
    logic        we;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        INT;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [31:0] cause;
        int          at;
    } exp_t;

    exp_t expq[$];

    int_controller #(
        .NUM_SRC (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .irq   (irq),
        .eret  (eret),
        .we    (we),
        .addr  (addr),
        .wdata (wdata),
        .rdata (rdata),
        .INT   (INT),
        .busy  (busy)
    );

    always #10 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every INT cycle must match the next queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (INT === 1'b1) begin
                checks++;
                if (expq.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL unexpected_int: INT=1 at cycle %0d, required INT=0", cyc);
                end else begin
                    e = expq.pop_front();
                    if ((cyc != e.at) || (rdata !== e.cause)) begin
                        errors++;
                        $display("[TB] FAIL int_event: cycle %0d cause %h, required cycle %0d cause %h",
                                 cyc, rdata, e.at, e.cause);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        #2;
    endtask

    task automatic applyStimulus(input logic w, input logic [1:0] a, input logic [31:0] d,
                                 input logic [7:0] i, input logic e);
        we    = w;
        addr  = a;
        wdata = d;
        irq   = i;
        eret  = e;
        tick();
        we    = 1'b0;
        eret  = 1'b0;
        addr  = ADDR_CAUSE;
        wdata = '0;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, required %h", name, actual, expected);
        end
    endtask

    task automatic checkReg(input string name, input logic [1:0] a, input logic [31:0] expected);
        addr = a;
        #1;
        checkOutput(name, rdata, expected);
        addr = ADDR_CAUSE;
    endtask

    task automatic expectInt(input logic [3:0] id, input int at);
        exp_t e;
        e.cause = 32'h8000_0000 | 32'(id);
        e.at    = at;
        expq.push_back(e);
    endtask

    task automatic pulse(input logic [7:0] bits);
        applyStimulus(1'b0, ADDR_CAUSE, 32'h0, bits, 1'b0);
        applyStimulus(1'b0, ADDR_CAUSE, 32'h0, 8'h00, 1'b0);
    endtask

    task automatic doEret();
        applyStimulus(1'b0, ADDR_CAUSE, 32'h0, 8'h00, 1'b1);
    endtask

    task automatic waitDrain(input string name);
        int n;
        n = 0;
        while ((expq.size() != 0) && (n < 12)) begin
            tick();
            n++;
        end
        if (expq.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s: %0d INT events still outstanding after %0d cycles, required 0",
                     name, expq.size(), n);
            expq.delete();
        end
    endtask

    initial begin
        reset = 1'b1;
        irq   = '0;
        eret  = 1'b0;
        we    = 1'b0;
        addr  = ADDR_CAUSE;
        wdata = '0;
        tick();
        tick();

        // Reset state
        checkOutput("reset_int", 32'(INT), 32'h0);
        checkOutput("reset_busy", 32'(busy), 32'h0);
        checkReg("reset_mask", ADDR_MASK, 32'h0);
        checkReg("reset_pending", ADDR_PENDING, 32'h0);
        checkReg("reset_cause", ADDR_CAUSE, 32'h0);
        reset = 1'b0;
        checkReg("reset_gie", ADDR_GIE, 32'h0);
        tick();

        // Single request on source 0
        applyStimulus(1'b1, ADDR_GIE, 32'h1, 8'h00, 1'b0);
        applyStimulus(1'b1, ADDR_MASK, 32'h1, 8'h00, 1'b0);
        checkReg("gie_rw", ADDR_GIE, 32'h1);
        checkReg("mask_rw", ADDR_MASK, 32'h1);
        expectInt(4'd0, cyc + LAT);
        pulse(8'h01);
        waitDrain("single_int");
        checkOutput("single_int_high", 32'(INT), 32'h1);
        checkOutput("single_busy_req", 32'(busy), 32'h1);
        tick();
        checkOutput("single_int_low", 32'(INT), 32'h0);
        checkReg("single_cause", ADDR_CAUSE, 32'h8000_0000);
        checkReg("single_pending", ADDR_PENDING, 32'h0);
        tick();
        tick();
        checkOutput("single_busy_svc", 32'(busy), 32'h1);
        doEret();
        checkOutput("single_busy_done", 32'(busy), 32'h0);
        checkReg("single_cause_done", ADDR_CAUSE, 32'h0);

        // Priority: sources 2 and 5 together
        applyStimulus(1'b1, ADDR_MASK, 32'hFF, 8'h00, 1'b0);
        expectInt(4'd2, cyc + LAT);
        pulse(8'h24);
        waitDrain("prio_first");
        tick();
        checkReg("prio_pending_mid", ADDR_PENDING, 32'h20);
        checkReg("prio_cause_first", ADDR_CAUSE, 32'h8000_0002);
        expectInt(4'd5, cyc + 2);
        doEret();
        waitDrain("prio_second");
        tick();
        doEret();
        checkReg("prio_pending_end", ADDR_PENDING, 32'h0);
        checkReg("prio_cause_held", ADDR_CAUSE, 32'h0000_0005);
        checkOutput("prio_busy_end", 32'(busy), 32'h0);

        // Masking and write-1-to-clear against a coinciding edge
        applyStimulus(1'b1, ADDR_MASK, 32'h00, 8'h00, 1'b0);
        pulse(8'h08);
        repeat (4) tick();
        checkReg("mask_pending_set", ADDR_PENDING, 32'h08);
        checkOutput("mask_no_busy", 32'(busy), 32'h0);
        expectInt(4'd3, cyc + 2);
        applyStimulus(1'b1, ADDR_MASK, 32'h08, 8'h00, 1'b0);
        waitDrain("mask_unmask_int");
        tick();
        checkReg("mask_pending_taken", ADDR_PENDING, 32'h0);
        applyStimulus(1'b1, ADDR_PENDING, 32'h08, 8'h08, 1'b0);
        applyStimulus(1'b0, ADDR_CAUSE, 32'h0, 8'h00, 1'b0);
        tick();
        tick();
        checkReg("pend_edge_wins", ADDR_PENDING, 32'h08);
        applyStimulus(1'b1, ADDR_PENDING, 32'h08, 8'h00, 1'b0);
        checkReg("pend_w1c", ADDR_PENDING, 32'h0);
        doEret();
        checkOutput("mask_busy_end", 32'(busy), 32'h0);

        // Controller clear coinciding with a new edge on the same source
        applyStimulus(1'b1, ADDR_GIE, 32'h0, 8'h00, 1'b0);
        applyStimulus(1'b1, ADDR_MASK, 32'h10, 8'h00, 1'b0);
        pulse(8'h10);
        repeat (3) tick();
        checkReg("clr_pending_pre", ADDR_PENDING, 32'h10);
        expectInt(4'd4, cyc + 2);
        applyStimulus(1'b1, ADDR_GIE, 32'h1, 8'h00, 1'b0);
        applyStimulus(1'b0, ADDR_CAUSE, 32'h0, 8'h10, 1'b0);
        waitDrain("clr_first");
        applyStimulus(1'b0, ADDR_CAUSE, 32'h0, 8'h00, 1'b0);
        tick();
        tick();
        checkReg("clr_vs_edge_pending", ADDR_PENDING, 32'h10);
        expectInt(4'd4, cyc + 2);
        doEret();
        waitDrain("clr_second");
        tick();
        doEret();
        checkReg("clr_pending_end", ADDR_PENDING, 32'h0);

        // No nesting; GIE/MASK clear during service; eret outside service
        applyStimulus(1'b1, ADDR_MASK, 32'hFF, 8'h00, 1'b0);
        expectInt(4'd0, cyc + LAT);
        pulse(8'h01);
        waitDrain("nest_first");
        tick();
        pulse(8'h02);
        repeat (5) tick();
        checkOutput("nest_busy_hold", 32'(busy), 32'h1);
        checkReg("nest_pending", ADDR_PENDING, 32'h02);
        expectInt(4'd1, cyc + 2);
        doEret();
        waitDrain("nest_second");
        tick();
        applyStimulus(1'b1, ADDR_GIE, 32'h0, 8'h00, 1'b0);
        applyStimulus(1'b1, ADDR_MASK, 32'h0, 8'h00, 1'b0);
        tick();
        checkOutput("svc_survives_clear", 32'(busy), 32'h1);
        checkReg("svc_cause", ADDR_CAUSE, 32'h8000_0001);
        doEret();
        checkOutput("svc_busy_end", 32'(busy), 32'h0);
        doEret();
        checkOutput("eret_idle_busy", 32'(busy), 32'h0);
        checkReg("eret_idle_cause", ADDR_CAUSE, 32'h0000_0001);

        // eret during REQ is ignored, then reset in the middle of service
        applyStimulus(1'b1, ADDR_GIE, 32'h1, 8'h00, 1'b0);
        applyStimulus(1'b1, ADDR_MASK, 32'h1, 8'h00, 1'b0);
        expectInt(4'd0, cyc + LAT);
        pulse(8'h01);
        waitDrain("rst_setup_int");
        doEret();
        checkOutput("eret_req_ignored", 32'(busy), 32'h1);
        irq   = 8'h02;
        reset = 1'b1;
        #1;
        checkOutput("rst_async_int", 32'(INT), 32'h0);
        checkOutput("rst_async_busy", 32'(busy), 32'h0);
        checkReg("rst_async_mask", ADDR_MASK, 32'h0);
        checkReg("rst_async_pending", ADDR_PENDING, 32'h0);
        checkReg("rst_async_cause", ADDR_CAUSE, 32'h0);
        checkReg("rst_async_gie", ADDR_GIE, 32'h0);
        tick();
        reset = 1'b0;
        repeat (REL_TICKS) tick();
        checkReg("edge_after_reset", ADDR_PENDING, 32'h02);
        checkOutput("edge_after_reset_busy", 32'(busy), 32'h0);
        irq = 8'h00;
        tick();
        waitDrain("final_drain");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
